// File: rtl/demux_bus_pkg.sv
// ---------------------------------------------------------------------------
// demux_bus_pkg
// Shared types and helpers for the handshaked one-to-many bus demultiplexer.
//   sel_mode_t     : how sel_in is interpreted (one-hot mask or binary index)
//   sel_decode_t   : decoded target mask plus illegal-select flag
//   decode_sel()   : turns a (zero-extended) select into a target mask
//   DROP_COUNT_WIDTH : width of the saturating dropped-beat counter
// ---------------------------------------------------------------------------
package demux_bus_pkg;

    localparam int DROP_COUNT_WIDTH = 16;

    // Upper bound on channel count; decode_sel works on masks of this width
    // so one function serves every BUS_WIDTH instantiation.
    localparam int MAX_BUS_WIDTH = 64;

    typedef enum logic {
        SEL_ONE_HOT = 1'b0,
        SEL_BINARY  = 1'b1
    } sel_mode_t;

    typedef struct packed {
        logic [MAX_BUS_WIDTH-1:0] mask;
        logic                     illegal;
    } sel_decode_t;

    // sel must be zero-extended by the caller. A beat that targets nothing
    // is always illegal; an illegal beat always carries an empty mask
    // except in the one-hot non-multicast case, where the caller must
    // ignore the mask because illegal is set.
    function automatic sel_decode_t decode_sel(
        input logic [MAX_BUS_WIDTH-1:0] sel,
        input int unsigned              bus_width,
        input sel_mode_t                mode,
        input logic                     multicast
    );
        sel_decode_t r;
        r.mask    = '0;
        r.illegal = 1'b0;
        if (mode == SEL_BINARY) begin
            if (sel >= 64'(bus_width)) begin
                r.illegal = 1'b1;
            end else begin
                r.mask = 64'(1) << sel[5:0];
            end
        end else begin
            r.mask = sel;
            // More than one bit set: sel & (sel-1) clears the lowest set bit.
            if (!multicast && ((sel & (sel - 64'd1)) != '0)) begin
                r.illegal = 1'b1;
            end
        end
        if (r.mask == '0) begin
            r.illegal = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_bus_channel_fifo.sv
// ---------------------------------------------------------------------------
// demux_bus_channel_fifo
// Per-channel elastic queue with first-word-fall-through head.
//   ap_clk, areset_n : clock, asynchronous active-low reset (pointers only)
//   push, push_data  : write request; ignored while full
//   pop              : read request; ignored while empty
//   full, empty      : status from registered pointers
//   head_data        : oldest entry, valid whenever empty is low
// ---------------------------------------------------------------------------
module demux_bus_channel_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  ap_clk,
    input  logic                  areset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head_data
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // One extra pointer bit distinguishes full from empty when the
    // address bits coincide.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    // Storage is deliberately left unreset; only the pointers define which
    // entries are meaningful.
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic do_push;
    logic do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A full queue refuses a push even when it is popped in the same cycle,
    // which keeps full independent of the consumer's ready.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign head_data = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/demux_bus_handshake.sv
// ---------------------------------------------------------------------------
// demux_bus_handshake
// One-to-many demultiplexer with valid/ready on both sides and a queue per
// output channel. Multicast writes are all-or-nothing.
//   ap_clk, areset_n   : clock, asynchronous active-low reset
//   sel_in             : target channel(s), one-hot mask or binary index
//   data_in/_valid/_ready : producer handshake
//   data_out[i]        : head of channel i queue
//   data_out_valid[i]  : channel i queue non-empty
//   data_out_ready[i]  : channel i consumer ready
//   sel_error          : sticky, set when an illegal-select beat is accepted
//   drop_count         : saturating count of illegal-select beats dropped
// ---------------------------------------------------------------------------
module demux_bus_handshake
    import demux_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 8,
    parameter int SEL_MODE   = 0,
    parameter int SEL_WIDTH  = (SEL_MODE == 0) ? BUS_WIDTH : $clog2(BUS_WIDTH),
    parameter int FIFO_DEPTH = 4,
    parameter int MULTICAST  = 1
) (
    input  logic                        ap_clk,
    input  logic                        areset_n,
    input  logic [SEL_WIDTH-1:0]        sel_in,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic [DATA_WIDTH-1:0]       data_out [BUS_WIDTH],
    output logic [BUS_WIDTH-1:0]        data_out_valid,
    input  logic [BUS_WIDTH-1:0]        data_out_ready,
    output logic                        sel_error,
    output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

    localparam sel_mode_t SEL_MODE_E = (SEL_MODE == 1) ? SEL_BINARY : SEL_ONE_HOT;

    logic [MAX_BUS_WIDTH-1:0] sel_ext;
    sel_decode_t              dec;
    logic [BUS_WIDTH-1:0]     target;
    logic [BUS_WIDTH-1:0]     full;
    logic [BUS_WIDTH-1:0]     empty;
    logic [BUS_WIDTH-1:0]     push_vec;
    logic                     accept;
    logic                     drop;

    logic                        sel_error_q, sel_error_d;
    logic [DROP_COUNT_WIDTH-1:0] drop_count_q, drop_count_d;

    // Decode and ready: ready depends only on sel_in and registered full
    // flags, so no path exists from any data_out_ready to data_in_ready.
    always_comb begin
        sel_ext                  = '0;
        sel_ext[SEL_WIDTH-1:0]   = sel_in;
        dec                      = decode_sel(sel_ext, 32'(BUS_WIDTH), SEL_MODE_E,
                                              (MULTICAST != 0));
        target                   = dec.mask[BUS_WIDTH-1:0];
        // Illegal beats are always taken so the producer never wedges on them.
        data_in_ready            = dec.illegal | ~(|(target & full));
        accept                   = data_in_valid & data_in_ready;
        drop                     = accept & dec.illegal;
        push_vec                 = (accept && !dec.illegal) ? target : '0;
    end

    generate
        if (BUS_WIDTH < MAX_BUS_WIDTH) begin : g_unused_mask
            logic unused_mask_bits;
            assign unused_mask_bits = ^dec.mask[MAX_BUS_WIDTH-1:BUS_WIDTH];
        end
    endgenerate

    always_comb begin
        sel_error_d  = sel_error_q | drop;
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            sel_error_q  <= 1'b0;
            drop_count_q <= '0;
        end else begin
            sel_error_q  <= sel_error_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign sel_error  = sel_error_q;
    assign drop_count = drop_count_q;

    genvar gi;
    generate
        for (gi = 0; gi < BUS_WIDTH; gi++) begin : g_chan
            demux_bus_channel_fifo #(
                .DATA_WIDTH (DATA_WIDTH),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .ap_clk    (ap_clk),
                .areset_n  (areset_n),
                .push      (push_vec[gi]),
                .push_data (data_in),
                .pop       (data_out_ready[gi]),
                .full      (full[gi]),
                .empty     (empty[gi]),
                .head_data (data_out[gi])
            );
            assign data_out_valid[gi] = ~empty[gi];
        end
    endgenerate

endmodule

// File: tb/tb_demux_bus_handshake.sv
module tb_demux_bus_handshake;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // One-hot multicast instance
    logic [7:0]  oh_sel;
    logic [31:0] oh_data;
    logic        oh_valid;
    logic        oh_in_ready;
    logic [31:0] oh_dout [8];
    logic [7:0]  oh_dv;
    logic [7:0]  oh_rdy;
    logic        oh_err;
    logic [15:0] oh_cnt;

    // Binary instance (4-bit select so out-of-range indices are reachable)
    logic [3:0]  bin_sel;
    logic [31:0] bin_data;
    logic        bin_valid;
    logic        bin_in_ready;
    logic [31:0] bin_dout [8];
    logic [7:0]  bin_dv;
    logic [7:0]  bin_rdy;
    logic        bin_err;
    logic [15:0] bin_cnt;

    demux_bus_handshake #(
        .DATA_WIDTH(32), .BUS_WIDTH(8), .SEL_MODE(0), .SEL_WIDTH(8),
        .FIFO_DEPTH(4), .MULTICAST(1)
    ) u_oh (
        .ap_clk(clk), .areset_n(rst_n), .sel_in(oh_sel), .data_in(oh_data),
        .data_in_valid(oh_valid), .data_in_ready(oh_in_ready),
        .data_out(oh_dout), .data_out_valid(oh_dv), .data_out_ready(oh_rdy),
        .sel_error(oh_err), .drop_count(oh_cnt)
    );

    demux_bus_handshake #(
        .DATA_WIDTH(32), .BUS_WIDTH(8), .SEL_MODE(1), .SEL_WIDTH(4),
        .FIFO_DEPTH(4), .MULTICAST(0)
    ) u_bin (
        .ap_clk(clk), .areset_n(rst_n), .sel_in(bin_sel), .data_in(bin_data),
        .data_in_valid(bin_valid), .data_in_ready(bin_in_ready),
        .data_out(bin_dout), .data_out_valid(bin_dv), .data_out_ready(bin_rdy),
        .sel_error(bin_err), .drop_count(bin_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one queue per channel per instance, plus error state.
    logic [31:0] mq [2][8][$];
    logic        merr [2];
    int          mcnt [2];
    logic        acc_last [2];

    // DUT values observed leaving specific channels
    logic [31:0] obs_b2 [$];
    logic [31:0] obs_o0 [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Target mask from the select rules; legal reports whether the beat is kept.
    function automatic logic [7:0] model_mask(input int d, output logic legal);
        if (d == 0) begin
            legal = (oh_sel != 8'd0);
            return oh_sel;
        end
        legal = (bin_sel < 4'd8);
        return legal ? (8'd1 << bin_sel[2:0]) : 8'd0;
    endfunction

    function automatic logic model_ready(input int d);
        logic       legal;
        logic [7:0] m;
        m = model_mask(d, legal);
        if (!legal) return 1'b1;
        for (int ch = 0; ch < 8; ch++) begin
            if (m[ch] && mq[d][ch].size() >= 4) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        logic [7:0]  m [2];
        logic        lg [2];
        logic [7:0]  rdy;
        logic [31:0] din;
        #1;
        for (int d = 0; d < 2; d++) begin
            logic [7:0] ev;
            logic       vin;
            logic       rdy_o;
            logic [7:0] dv_o;
            logic       err_o;
            logic [15:0] cnt_o;
            ev = 8'd0;
            for (int ch = 0; ch < 8; ch++) ev[ch] = (mq[d][ch].size() != 0);
            m[d]  = model_mask(d, lg[d]);
            vin   = (d == 0) ? oh_valid : bin_valid;
            rdy_o = (d == 0) ? oh_in_ready : bin_in_ready;
            dv_o  = (d == 0) ? oh_dv : bin_dv;
            err_o = (d == 0) ? oh_err : bin_err;
            cnt_o = (d == 0) ? oh_cnt : bin_cnt;
            chk($sformatf("ready_d%0d", d), 64'(rdy_o), 64'(model_ready(d)));
            chk($sformatf("valid_d%0d", d), 64'(dv_o), 64'(ev));
            for (int ch = 0; ch < 8; ch++) begin
                if (ev[ch]) begin
                    chk($sformatf("head_d%0d_ch%0d", d, ch),
                        64'((d == 0) ? oh_dout[ch] : bin_dout[ch]), 64'(mq[d][ch][0]));
                end
            end
            chk($sformatf("sel_error_d%0d", d), 64'(err_o), 64'(merr[d]));
            chk($sformatf("drop_count_d%0d", d), 64'(cnt_o), 64'(mcnt[d]));
            acc_last[d] = vin & model_ready(d);
        end
        if (bin_dv[2] && bin_rdy[2]) obs_b2.push_back(bin_dout[2]);
        if (oh_dv[0] && oh_rdy[0])   obs_o0.push_back(oh_dout[0]);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            rdy = (d == 0) ? oh_rdy : bin_rdy;
            din = (d == 0) ? oh_data : bin_data;
            for (int ch = 0; ch < 8; ch++) begin
                if (mq[d][ch].size() != 0 && rdy[ch]) void'(mq[d][ch].pop_front());
            end
            if (acc_last[d]) begin
                if (lg[d]) begin
                    for (int ch = 0; ch < 8; ch++) begin
                        if (m[d][ch]) mq[d][ch].push_back(din);
                    end
                    $display("push dut%0d mask=%02h data=%08h", d, m[d], din);
                end else begin
                    merr[d] = 1'b1;
                    if (mcnt[d] < 16'hFFFF) mcnt[d]++;
                    $display("drop dut%0d data=%08h count=%0d", d, din, mcnt[d]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        oh_valid  = 1'b0;
        bin_valid = 1'b0;
        oh_rdy    = 8'hFF;
        bin_rdy   = 8'hFF;
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < 8; ch++) mq[d][ch].delete();
            merr[d] = 1'b0;
            mcnt[d] = 0;
        end
    endtask

    initial begin
        int next;
        rst_n    = 1'b0;
        oh_sel   = 8'd0;
        oh_data  = 32'd0;
        bin_sel  = 4'd0;
        bin_data = 32'd0;
        set_idle();
        clear_model();
        repeat (2) @(negedge clk);

        // Reset state; ready high for any select with empty queues
        #1;
        chk("rst_oh_valid", 64'(oh_dv), 64'd0);
        chk("rst_bin_valid", 64'(bin_dv), 64'd0);
        chk("rst_oh_err", 64'(oh_err), 64'd0);
        chk("rst_bin_cnt", 64'(bin_cnt), 64'd0);
        chk("rst_oh_ready_illegal", 64'(oh_in_ready), 64'd1);
        chk("rst_bin_ready_legal", 64'(bin_in_ready), 64'd1);
        oh_sel  = 8'h83;
        bin_sel = 4'd9;
        #1;
        chk("rst_oh_ready_mc", 64'(oh_in_ready), 64'd1);
        chk("rst_bin_ready_illegal", 64'(bin_in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        $display("step: reset released");

        // Binary single beat to channel 5
        bin_sel   = 4'd5;
        bin_data  = 32'hDEADBEEF;
        bin_valid = 1'b1;
        cycle();
        bin_valid = 1'b0;
        #1;
        chk("bin5_valid", 64'(bin_dv), 64'h20);
        chk("bin5_data", 64'(bin_dout[5]), 64'hDEADBEEF);
        cycle();
        $display("step: binary beat to channel 5");

        // Multicast all-or-nothing with channel 7 stalled full
        oh_rdy[7] = 1'b0;
        oh_sel    = 8'h80;
        oh_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            oh_data = 32'd100 + 32'(i);
            cycle();
        end
        oh_sel  = 8'h83;
        oh_data = 32'd200;
        #1;
        chk("mc_blocked", 64'(oh_in_ready), 64'd0);
        cycle();
        chk("mc_no_partial", 64'(oh_dv), 64'h80);
        oh_rdy[7] = 1'b1;
        cycle();
        oh_rdy[7] = 1'b0;
        cycle();
        oh_valid = 1'b0;
        #1;
        chk("mc_landed_valid", 64'(oh_dv), 64'h83);
        chk("mc_ch0", 64'(oh_dout[0]), 64'd200);
        chk("mc_ch1", 64'(oh_dout[1]), 64'd200);
        chk("mc_ch7_head", 64'(oh_dout[7]), 64'd101);
        oh_rdy = 8'hFF;
        repeat (6) cycle();
        $display("step: multicast");

        // Backpressure ordering on binary channel 2
        obs_b2.delete();
        bin_rdy[2] = 1'b0;
        bin_sel    = 4'd2;
        bin_valid  = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            bin_data = 32'(v);
            cycle();
        end
        bin_data = 32'd5;
        #1;
        chk("bp_full", 64'(bin_in_ready), 64'd0);
        bin_rdy[2] = 1'b1;
        next = 5;
        for (int k = 0; k < 30 && next <= 6; k++) begin
            bin_data = 32'(next);
            cycle();
            if (acc_last[1]) next++;
        end
        chk("bp_accept_all", 64'(next), 64'd7);
        bin_valid = 1'b0;
        repeat (8) cycle();
        chk("bp_count", 64'(obs_b2.size()), 64'd6);
        for (int i = 0; i < 6 && i < obs_b2.size(); i++) begin
            chk($sformatf("bp_order_%0d", i), 64'(obs_b2[i]), 64'(i + 1));
        end
        $display("step: backpressure ordering");

        // Illegal binary select
        bin_sel   = 4'd9;
        bin_valid = 1'b1;
        repeat (3) cycle();
        bin_valid = 1'b0;
        #1;
        chk("ill_valid", 64'(bin_dv), 64'd0);
        chk("ill_err", 64'(bin_err), 64'd1);
        chk("ill_cnt", 64'(bin_cnt), 64'd3);
        cycle();
        $display("step: illegal select");

        // Full with simultaneous pops on one-hot channel 0
        obs_o0.delete();
        oh_sel   = 8'h01;
        oh_valid = 1'b1;
        next = 0;
        for (int k = 0; k < 40 && next < 5; k++) begin
            oh_data   = 32'h500 + 32'(next);
            oh_rdy[0] = ((k % 3) == 2);
            cycle();
            if (acc_last[0]) next++;
        end
        oh_valid = 1'b0;
        oh_rdy   = 8'hFF;
        repeat (8) cycle();
        chk("fp_count", 64'(obs_o0.size()), 64'd5);
        for (int i = 0; i < 5 && i < obs_o0.size(); i++) begin
            chk($sformatf("fp_order_%0d", i), 64'(obs_o0[i]), 64'(32'h500 + 32'(i)));
        end
        $display("step: full with pop");

        // Randomised traffic against the model
        for (int n = 0; n < 300; n++) begin
            oh_sel = 8'($urandom);
            if ($urandom_range(0, 7) == 0) oh_sel = 8'd0;
            oh_data   = $urandom;
            oh_valid  = 1'($urandom_range(0, 1));
            oh_rdy    = 8'($urandom) | 8'($urandom);
            bin_sel   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15))
                                                    : 4'($urandom_range(0, 7));
            bin_data  = $urandom;
            bin_valid = 1'($urandom_range(0, 1));
            bin_rdy   = 8'($urandom) | 8'($urandom);
            cycle();
        end
        set_idle();
        repeat (10) cycle();
        $display("step: random traffic");

        // Reset mid-stream with channels 2 and 4 holding three entries
        oh_rdy[2] = 1'b0;
        oh_rdy[4] = 1'b0;
        oh_sel    = 8'h14;
        oh_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            oh_data = 32'h700 + 32'(i);
            cycle();
        end
        oh_valid = 1'b0;
        #1;
        chk("mid_pre_valid", 64'(oh_dv), 64'h14);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_oh_valid", 64'(oh_dv), 64'd0);
        chk("mid_rst_bin_valid", 64'(bin_dv), 64'd0);
        chk("mid_rst_bin_err", 64'(bin_err), 64'd0);
        chk("mid_rst_bin_cnt", 64'(bin_cnt), 64'd0);
        clear_model();
        set_idle();
        cycle();
        rst_n = 1'b1;
        oh_sel   = 8'h04;
        oh_data  = 32'hCAFE0001;
        oh_valid = 1'b1;
        cycle();
        oh_valid = 1'b0;
        #1;
        chk("post_rst_valid", 64'(oh_dv), 64'h04);
        chk("post_rst_data", 64'(oh_dout[2]), 64'hCAFE0001);
        cycle();
        $display("step: reset mid-stream");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
